// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg -- shared types and helpers for the shared-adder scheduler.
//   sched_state_e : output-slot state (EMPTY / FULL)
//   MAX_IDW       : widest requester ID supported (R <= 16)
//   id_w()        : requester-ID width for a given requester count
//   next_ptr()    : round-robin successor of a requester index, modulo R
package adder_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_e;

  localparam int MAX_IDW = 4;

  // ID width for r requesters; never below 1 so the ID port always exists.
  function automatic int id_w(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

  // Successor of ptr in a ring of r requesters.
  function automatic logic [MAX_IDW-1:0] next_ptr(input logic [MAX_IDW-1:0] ptr,
                                                  input int r);
    return (ptr == MAX_IDW'(r - 1)) ? '0 : MAX_IDW'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/adder_sched_add.sv
// adder_sched_add -- the shared N-bit combinational adder element.
//   a, b  in  N  operands
//   cin   in  1  carry-in
//   sum   out N  sum modulo 2^N
//   cout  out 1  carry-out of the N-bit add
module adder_sched_add #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Full N+1-bit add so the carry is never truncated.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/adder_sched_rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin pick.
//   req     in  R    request vector
//   ptr     in  IDW  highest-priority index this cycle
//   en      in  1    grant allowed (slot can accept)
//   gnt     out R    one-hot grant, all zero when disabled or idle
//   gnt_idx out IDW  index of the granted requester (valid when any_gnt)
//   any_gnt out 1    a grant is issued this cycle
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_gnt
);

  logic [IDW-1:0] idx;
  logic           hit;

  // Scan the ring from the farthest offset back to ptr itself so that the
  // last hit written is the one closest to ptr.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      if (req[IDW'((int'(ptr) + k) % R)]) begin
        idx = IDW'((int'(ptr) + k) % R);
        hit = 1'b1;
      end
    end
  end

  assign any_gnt = en & hit;
  assign gnt_idx = idx;
  assign gnt     = any_gnt ? (R'(1) << idx) : '0;

endmodule

// File: rtl/adder_sched.sv
// adder_sched -- round-robin scheduler sharing one N-bit adder among R
// requesters, with a single registered result slot.
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   req_valid  in   R      per-requester operand valid
//   req_ready  out  R      per-requester accept (at most one hot)
//   req_a      in   R*N    packed operand A, requester i at [i*N +: N]
//   req_b      in   R*N    packed operand B, same packing
//   req_cin    in   R      per-requester carry-in
//   res_valid  out  1      result slot occupied
//   res_ready  in   1      consumer takes the result
//   res_sum    out  N      registered sum
//   res_cout   out  1      registered carry-out
//   res_id     out  IDW    requester that produced the result
//   res_ovf    out  1      signed overflow (only with ADDER_SCHED_OVF_EN)
// Build option: define ADDER_SCHED_OVF_EN to add the res_ovf output.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_cin,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_sum,
  output logic           res_cout,
  output logic [IDW-1:0] res_id
`ifdef ADDER_SCHED_OVF_EN
  ,
  output logic           res_ovf
`endif
);

  typedef struct packed {
    logic           cout;
    logic [N-1:0]   sum;
    logic [IDW-1:0] id;
`ifdef ADDER_SCHED_OVF_EN
    logic           ovf;
`endif
  } res_t;

  sched_state_e        state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  res_t                res_q, res_d;

  logic [R-1:0][N-1:0] a_arr, b_arr;
  logic [R-1:0]        gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                any_gnt;
  logic                can_accept;
  logic                xfer;
  logic                consume;
  logic [N-1:0]        a_sel, b_sel, sum_w;
  logic                cin_sel, cout_w;

  assign a_arr = req_a;
  assign b_arr = req_b;

  assign res_valid  = (state_q == FULL);
  assign consume    = res_valid & res_ready;
  assign can_accept = (state_q == EMPTY) | consume;

  // rst gates the arbiter so no ready is advertised while held in reset,
  // even though the slot itself reads as EMPTY then.
  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (can_accept & rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign req_ready = gnt;
  assign xfer      = any_gnt;

  // Operand steering into the single shared adder.
  assign a_sel   = a_arr[gnt_idx];
  assign b_sel   = b_arr[gnt_idx];
  assign cin_sel = req_cin[gnt_idx];

  adder_sched_add #(.N(N)) u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (sum_w),
    .cout (cout_w)
  );

  // Next-state and next-result. A transfer wins over a plain consume, which
  // gives back-to-back replacement with no bubble. A consume alone only
  // frees the slot; the data fields keep their last values.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    if (xfer) begin
      state_d   = FULL;
      res_d.sum  = sum_w;
      res_d.cout = cout_w;
      res_d.id   = gnt_idx;
`ifdef ADDER_SCHED_OVF_EN
      res_d.ovf  = (a_sel[N-1] == b_sel[N-1]) & (sum_w[N-1] != a_sel[N-1]);
`endif
    end else if (consume) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      ptr_q <= '0;
    end else begin
      res_q <= res_d;
      // Pointer only advances past a granted requester; idle and
      // backpressured cycles leave it alone.
      if (xfer) ptr_q <= IDW'(next_ptr(MAX_IDW'(gnt_idx), R));
    end
  end

  assign res_sum  = res_q.sum;
  assign res_cout = res_q.cout;
  assign res_id   = res_q.id;
`ifdef ADDER_SCHED_OVF_EN
  assign res_ovf  = res_q.ovf;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched -- directed self-checking bench for adder_sched (N=8, R=4).
// Build option: ADDER_SCHED_OVF_EN adds checks on res_ovf.
module tb_adder_sched;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_cin;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_sum;
  logic           res_cout;
  logic [1:0]     res_id;
`ifdef ADDER_SCHED_OVF_EN
  logic           res_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_sched #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
`ifdef ADDER_SCHED_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_cin[i]      = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected round-robin sequence starting at ptr=1, and per-requester sums
  // for operands a=0x10*(i+1), b=i, cin=i[0].
  logic [1:0] rr_id  [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rr_sum [4] = '{8'h10, 8'h22, 8'h32, 8'h44};

  initial begin
    bit found;
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    res_ready = 1'b0;

    // Reset state, with a request pending to show ready stays low.
    req_valid = 4'b0001;
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_sum",   32'(res_sum),   0);
    chk("rst_cout",  32'(res_cout),  0);
    chk("rst_id",    32'(res_id),    0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single requester 2: 0x12 + 0x34 + 1 = 0x47.
    set_op(2, 8'h12, 8'h34, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 'h4);
    step();
    req_valid = '0;
    chk("single_valid", 32'(res_valid), 1);
    chk("single_sum",   32'(res_sum),   'h47);
    chk("single_cout",  32'(res_cout),  0);
    chk("single_id",    32'(res_id),    2);
    res_ready = 1'b1;
    step();
    chk("consume_valid", 32'(res_valid), 0);
    chk("consume_hold",  32'(res_sum),   'h47);

    // Carry/wrap on requester 0 (ptr is 3, wraps to 0): 0xFF + 0x01.
    set_op(0, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("wrap_ready", 32'(req_ready), 'h1);
    step();
    req_valid = '0;
    chk("wrap_sum",  32'(res_sum),  'h00);
    chk("wrap_cout", 32'(res_cout), 1);
    chk("wrap_id",   32'(res_id),   0);
    step();
    chk("wrap_empty", 32'(res_valid), 0);

    // All four valid, res_ready high: one result per cycle from ptr=1.
    for (int i = 0; i < R; i++) set_op(i, 8'((i + 1) * 16), 8'(i), i[0]);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1) << rr_id[k]);
      step();
      chk("rr_valid", 32'(res_valid), 1);
      chk("rr_id",    32'(res_id),    32'(rr_id[k]));
      chk("rr_sum",   32'(res_sum),   32'(rr_sum[rr_id[k]]));
    end

    // Backpressure: slot holds id 0 / 0x10, ptr stays at 1.
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 0);
      step();
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_id",    32'(res_id),    0);
      chk("bp_sum",   32'(res_sum),   'h10);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 'h2);
    step();
    chk("bp_release_valid", 32'(res_valid), 1);
    chk("bp_release_id",    32'(res_id),    1);
    chk("bp_release_sum",   32'(res_sum),   'h22);

    // Fairness: req 0 alone for a few transfers, then req 3 joins.
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fair_solo_id", 32'(res_id), 0);
    end
    req_valid = 4'b1001;
    found = 1'b0;
    for (int k = 0; k < R && !found; k++) begin
      step();
      if (res_valid && res_id == 2'd3) found = 1'b1;
    end
    chk("fair_req3", 32'(found), 1);
    chk("fair_sum3", 32'(res_sum), 'h44);

    // Reset asserted while FULL clears everything immediately.
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_sum",   32'(res_sum),   0);
    chk("mid_rst_cout",  32'(res_cout),  0);
    chk("mid_rst_id",    32'(res_id),    0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    set_op(1, 8'h05, 8'h06, 1'b0);
    req_valid = 4'b1010;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 'h2);
    step();
    chk("post_rst_id",  32'(res_id),  1);
    chk("post_rst_sum", 32'(res_sum), 'h0B);

    // Signed overflow vector on requester 2 (ptr is 2): 0x7F + 0x01.
    req_valid = '0;
    set_op(2, 8'h7F, 8'h01, 1'b0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("ovf_sum",  32'(res_sum),  'h80);
    chk("ovf_cout", 32'(res_cout), 0);
    chk("ovf_id",   32'(res_id),   2);
`ifdef ADDER_SCHED_OVF_EN
    chk("ovf_flag", 32'(res_ovf), 1);
`endif
    step();
    chk("final_empty", 32'(res_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end

endmodule
